// File: rtl/uart_tx_pkg.sv
// Shared types and status-byte layout for the buffered Z80 UART transmitter.
package uart_tx_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_e;

    localparam int ST_BUSY    = 0;
    localparam int ST_FULL    = 1;
    localparam int ST_OVF     = 2;
    localparam int ST_CNT_LSB = 3;
    localparam int ST_CNT_W   = 8 - ST_CNT_LSB;
    localparam int ST_CNT_MAX = (1 << ST_CNT_W) - 1;

endpackage

// File: rtl/io_fifo.sv
// Synchronous first-word-fall-through FIFO with occupancy count.
module io_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  push_i,
    input  logic [WIDTH-1:0]      data_i,
    input  logic                  pop_i,
    output logic [WIDTH-1:0]      data_o,
    output logic                  full_o,
    output logic                  empty_o,
    output logic [DEPTH_LOG2:0]   count_o
);

    localparam int DEPTH = 1 << DEPTH_LOG2;

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr_q, rd_ptr_q;
    logic [DEPTH_LOG2:0]   count_q;
    logic                  do_push, do_pop;

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // NOTE: storage is not reset; the pointers and count alone say which entries are valid.
    always_ff @(posedge clk_i) begin
        if (do_push) mem_q[wr_ptr_q] <= data_i;
    end

    assign data_o  = mem_q[rd_ptr_q];
    assign full_o  = count_q[DEPTH_LOG2];
    assign empty_o = (count_q == '0);
    assign count_o = count_q;

endmodule

// File: rtl/io_uart_tx.sv
// Buffered 8N1 UART transmitter on the Z80 I/O bus with a pollable status port.
// Define UART_TX_FIFO_EN for a 2^DEPTH_LOG2 FIFO; otherwise a single holding register is used.
module io_uart_tx
    import uart_tx_pkg::*;
#(
    parameter int         CLK_HZ      = 50000000,
    parameter int         BAUD        = 115200,
    parameter logic [7:0] PORT_DATA   = 8'h08,
    parameter logic [7:0] PORT_STATUS = 8'h09,
    parameter int         DEPTH_LOG2  = 4
) (
    input  logic       clk,
    input  logic       nRESET,
    input  logic [7:0] Address,
    input  logic [7:0] DataIn,
    output logic [7:0] DataOut,
    output logic       DataOE,
    input  logic       IORQ,
    input  logic       RD,
    input  logic       WR,
    output logic       uart_tx
);

    localparam int DIV    = CLK_HZ / BAUD;
    localparam int BAUD_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int QCNT_W = DEPTH_LOG2 + 1;
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(DIV - 1);

    logic [1:0] wr_sync_q, rd_sync_q;
    logic       wr_prev_q, rd_prev_q;
    logic       push_req, push_ok, rd_fall;

    logic              q_full, q_empty, pop;
    logic [7:0]        q_data;
    logic [QCNT_W-1:0] q_count;

    tx_state_e         state_q, state_d;
    logic [BAUD_W-1:0] baud_q, baud_d;
    logic [2:0]        bit_q, bit_d;
    logic [7:0]        shift_q, shift_d;
    logic              tx_q, tx_d;
    logic              ovf_q, ovf_d;
    logic              baud_last, busy;
    logic [ST_CNT_W-1:0] st_cnt;

    assign DataOE = IORQ & RD & (Address == PORT_STATUS);

    always_ff @(posedge clk) begin
        if (!nRESET) begin
            wr_sync_q <= '0;
            rd_sync_q <= '0;
            wr_prev_q <= 1'b0;
            rd_prev_q <= 1'b0;
        end else begin
            wr_sync_q <= {wr_sync_q[0], IORQ & WR};
            rd_sync_q <= {rd_sync_q[0], DataOE};
            wr_prev_q <= wr_sync_q[1];
            rd_prev_q <= rd_sync_q[1];
        end
    end

    assign push_req = wr_sync_q[1] & ~wr_prev_q & (Address == PORT_DATA);
    assign rd_fall  = ~rd_sync_q[1] & rd_prev_q;
    assign push_ok  = push_req & (~q_full | pop);

`ifdef UART_TX_FIFO_EN
    io_fifo #(
        .WIDTH      (8),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk_i   (clk),
        .rst_ni  (nRESET),
        .push_i  (push_ok),
        .data_i  (DataIn),
        .pop_i   (pop),
        .data_o  (q_data),
        .full_o  (q_full),
        .empty_o (q_empty),
        .count_o (q_count)
    );
`else
    logic       hold_valid_q;
    logic [7:0] hold_data_q;

    always_ff @(posedge clk) begin
        if (!nRESET)      hold_valid_q <= 1'b0;
        else if (push_ok) hold_valid_q <= 1'b1;
        else if (pop)     hold_valid_q <= 1'b0;
    end

    always_ff @(posedge clk) begin
        if (push_ok) hold_data_q <= DataIn;
    end

    assign q_full  = hold_valid_q;
    assign q_empty = ~hold_valid_q;
    assign q_data  = hold_data_q;
    assign q_count = QCNT_W'(hold_valid_q);
`endif

    assign baud_last = (baud_q == BAUD_LAST);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop     = 1'b0;
        case (state_q)
            IDLE: begin
                if (!q_empty) begin
                    pop     = 1'b1;
                    shift_d = q_data;
                    baud_d  = '0;
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (baud_last) begin
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    state_d = DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    bit_d   = bit_q + 3'd1;
                    if (bit_q == 3'd7) state_d = STOP;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            STOP: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (!q_empty) begin
                        pop     = 1'b1;
                        shift_d = q_data;
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Overflow set takes priority over the read-side clear.
    always_comb begin
        ovf_d = ovf_q;
        if (rd_fall)             ovf_d = 1'b0;
        if (push_req && !push_ok) ovf_d = 1'b1;
    end

    // tx_q is registered from the current state, so the line trails the FSM by one clk.
    always_ff @(posedge clk) begin
        if (!nRESET) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= 3'd0;
            shift_q <= 8'h00;
            tx_q    <= 1'b1;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ovf_q   <= ovf_d;
        end
    end

    assign uart_tx = tx_q;
    assign busy    = (state_q != IDLE) | ~q_empty;
    assign st_cnt  = (int'(q_count) > ST_CNT_MAX) ? ST_CNT_W'(ST_CNT_MAX) : ST_CNT_W'(q_count);

    always_comb begin
        DataOut                   = 8'h00;
        DataOut[ST_BUSY]          = busy;
        DataOut[ST_FULL]          = q_full;
        DataOut[ST_OVF]           = ovf_q;
        DataOut[7:ST_CNT_LSB]     = st_cnt;
    end

endmodule
